// File: rtl/sig_dump_engine.sv
// Compliance-signature engine: snoops begin/end/halt marker writes, then reads the signature region
// (one outstanding read) and streams it; halt write at N gives rd_req at N+2, output word held until sig_ready.
module sig_dump_engine #(
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter logic [AW-1:0]   BEGIN_ADDR = 'h508,
  parameter logic [AW-1:0]   END_ADDR   = 'h50c,
  parameter logic [AW-1:0]   HALT_ADDR  = 'h600,
  parameter logic [AW-1:0]   MEM_BASE   = 'h4000_0000,
  parameter int              MAX_WORDS  = 1024,
  parameter int              TMO_W      = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          mon_we,
  input  logic [AW-1:0] mon_addr,
  input  logic [DW-1:0] mon_wdat,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_gnt,
  input  logic          rd_vld,
  input  logic [DW-1:0] rd_dat,
  output logic          sig_valid,
  output logic [DW-1:0] sig_data,
  output logic          sig_last,
  input  logic          sig_ready,
  output logic          busy,
  output logic          done,
  output logic          err_range,
  output logic          err_timeout,
  output logic [15:0]   word_cnt
);

  localparam int              BPW     = DW / 8;
  localparam int              SHIFT   = $clog2(BPW);
  localparam logic [AW-1:0]   BPW_A   = AW'(BPW);
  localparam logic [AW-1:0]   ALIGN_M = BPW_A - AW'(1);
  localparam logic [AW-1:0]   MAXW_A  = AW'(MAX_WORDS);
  localparam logic [TMO_W-1:0] TMO_LIM = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CHECK, S_RDREQ, S_RDWAIT, S_OUT, S_DONE, S_ERR
  } state_t;

  state_t           state, nxt;
  logic [AW-1:0]    beg_r, end_r, ptr, span;
  logic             beg_v, end_v;
  logic [TMO_W-1:0] wd;
  logic             stale;
  logic             ptr_bad, last_word, halt_hit, take_rd, hs, abandon;

  assign span      = end_r - beg_r;
  assign halt_hit  = mon_we && (mon_addr == HALT_ADDR);
  assign take_rd   = rd_vld && !stale;
  assign hs        = (state == S_OUT) && sig_ready;
  assign last_word = (ptr + BPW_A) == end_r;

  // A read granted (or still in flight) when the dump is aborted leaves one
  // response owed to us; the stale flag swallows it so a later dump never sees it.
  assign abandon = !enable && (((state == S_RDREQ) && rd_gnt) ||
                               ((state == S_RDWAIT) && !take_rd));

  always_comb begin
    ptr_bad = !beg_v || !end_v ||
              (end_r < beg_r) ||
              (beg_r < MEM_BASE) ||
              ((beg_r & ALIGN_M) != '0) ||
              ((end_r & ALIGN_M) != '0) ||
              ((span >> SHIFT) > MAXW_A);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!enable) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   nxt = S_ARMED;
        S_ARMED: begin
          if (halt_hit)          nxt = S_CHECK;
          else if (wd == TMO_LIM) nxt = S_ERR;
        end
        S_CHECK: begin
          if (ptr_bad)             nxt = S_ERR;
          else if (end_r == beg_r) nxt = S_DONE;
          else                     nxt = S_RDREQ;
        end
        S_RDREQ:  if (rd_gnt)  nxt = S_RDWAIT;
        S_RDWAIT: if (take_rd) nxt = S_OUT;
        S_OUT:    if (sig_ready) nxt = last_word ? S_DONE : S_RDREQ;
        S_DONE:   nxt = S_DONE;
        S_ERR:    nxt = S_ERR;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_req    = (state == S_RDREQ);
    rd_addr   = ptr;
    sig_valid = (state == S_OUT);
    sig_last  = (state == S_OUT) && last_word;
    busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beg_r       <= '0;
      end_r       <= '0;
      beg_v       <= 1'b0;
      end_v       <= 1'b0;
      ptr         <= '0;
      wd          <= '0;
      stale       <= 1'b0;
      sig_data    <= '0;
      done        <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      word_cnt    <= '0;
    end else begin
      if ((state == S_IDLE) && enable) begin
        done        <= 1'b0;
        err_range   <= 1'b0;
        err_timeout <= 1'b0;
        word_cnt    <= '0;
        wd          <= '0;
        beg_v       <= 1'b0;
        end_v       <= 1'b0;
      end
      // Pointer markers are only sampled while armed, so they stay frozen during a dump.
      if (state == S_ARMED) begin
        wd <= wd + TMO_W'(1);
        if (mon_we && (mon_addr == BEGIN_ADDR)) begin
          beg_r <= AW'(mon_wdat);
          beg_v <= 1'b1;
        end
        if (mon_we && (mon_addr == END_ADDR)) begin
          end_r <= AW'(mon_wdat);
          end_v <= 1'b1;
        end
      end
      if (state == S_CHECK) ptr <= beg_r;
      if (hs) begin
        ptr      <= ptr + BPW_A;
        word_cnt <= word_cnt + 16'd1;
      end
      if ((state == S_RDWAIT) && take_rd) sig_data <= rd_dat;
      if ((nxt == S_DONE) && (state != S_DONE)) done <= 1'b1;
      if ((state == S_CHECK) && (nxt == S_ERR)) err_range <= 1'b1;
      if ((state == S_ARMED) && (nxt == S_ERR)) err_timeout <= 1'b1;
      stale <= (stale && !rd_vld) || abandon;
    end
  end

endmodule

// File: tb/tb_sig_dump_engine.sv
// Self-checking bench for sig_dump_engine: vector table, hand-written corner sequences and
// randomized dumps checked against a plain-arithmetic signature model.
module tb_sig_dump_engine;

  localparam logic [31:0] BEGIN_A = 32'h508;
  localparam logic [31:0] END_A   = 32'h50c;
  localparam logic [31:0] HALT_A  = 32'h600;

  logic        clk, rst_n, enable, mon_we;
  logic [31:0] mon_addr, mon_wdat;
  logic        rd_req, rd_gnt, rd_vld;
  logic [31:0] rd_addr, rd_dat;
  logic        sig_valid, sig_last, sig_ready;
  logic [31:0] sig_data;
  logic        busy, done, err_range, err_timeout;
  logic [15:0] word_cnt;

  sig_dump_engine #(.TMO_W(4), .MAX_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdat(mon_wdat),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_dat(rd_dat),
    .sig_valid(sig_valid), .sig_data(sig_data), .sig_last(sig_last), .sig_ready(sig_ready),
    .busy(busy), .done(done), .err_range(err_range), .err_timeout(err_timeout),
    .word_cnt(word_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nerr = 0;
  int nchk = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5C3_0000 ^ {a[15:0], 16'h0};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Memory responder: grants when idle, returns data lat_cfg cycles after the grant.
  int          lat_cfg = 1;
  int          gnt_mod = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  initial begin
    rd_gnt = 1'b0; rd_vld = 1'b0; rd_dat = 32'h0;
    forever begin
      @(negedge clk); #1;
      rd_gnt = 1'b0;
      rd_vld = 1'b0;
      if (!rst_n) begin
        pend_cnt = 0;
      end else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            rd_vld = 1'b1;
            rd_dat = mem(pend_addr);
          end
        end
        if (rd_req && (pend_cnt == 0) && ($urandom_range(0, gnt_mod - 1) == 0)) begin
          rd_gnt    = 1'b1;
          pend_addr = rd_addr;
          pend_cnt  = lat_cfg;
        end
      end
    end
  end

  // Sink: ready pattern per rmode, records accepted words and checks held words stay stable.
  int          rmode = 0;
  logic        manual_rdy = 1'b0;
  int          cyc = 0;
  logic [31:0] got_dat[$];
  bit          got_last[$];
  int          rdreq_cyc = 0, valid_cyc = 0, stab_err = 0;
  bit          hold_v = 1'b0, hold_l = 1'b0;
  logic [31:0] hold_d = 32'h0;
  initial begin
    sig_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      case (rmode)
        0:       sig_ready = 1'b1;
        1:       sig_ready = (cyc % 3 == 0);
        2:       sig_ready = ($urandom_range(0, 1) == 1);
        default: sig_ready = manual_rdy;
      endcase
      if (rd_req)    rdreq_cyc++;
      if (sig_valid) valid_cyc++;
      if (hold_v && (!sig_valid || sig_data !== hold_d || sig_last !== hold_l)) stab_err++;
      if (sig_valid && sig_ready) begin
        got_dat.push_back(sig_data);
        got_last.push_back(sig_last);
      end
      hold_v = sig_valid && !sig_ready && enable && rst_n;
      hold_d = sig_data;
      hold_l = sig_last;
    end
  end

  task automatic clear_obs();
    got_dat.delete();
    got_last.delete();
    rdreq_cyc = 0;
    valid_cyc = 0;
    stab_err  = 0;
  endtask

  task automatic arm();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    clear_obs();
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mon_we = 1'b1; mon_addr = a; mon_wdat = d;
    @(negedge clk);
    mon_we = 1'b0;
  endtask

  // Optionally keeps hammering the pointer markers to show they are frozen mid-dump.
  task automatic wait_end(input string nm, input bit junk);
    int n = 0;
    while (!(done || err_range || err_timeout) && n < 300) begin
      if (junk) begin
        mon_we = 1'b1;
        mon_addr = n[0] ? END_A : BEGIN_A;
        mon_wdat = $urandom;
      end
      @(negedge clk);
      n++;
    end
    mon_we = 1'b0;
    check({nm, "_finished"}, 32'(done | err_range | err_timeout), 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!sig_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(sig_valid), 32'd1);
  endtask

  task automatic verify(input string nm, input logic [31:0] b, input bit exp_err, input int exp_nw);
    check({nm, "_err_range"}, 32'(err_range), 32'(exp_err));
    check({nm, "_done"}, 32'(done), 32'(!exp_err));
    check({nm, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_nwords"}, 32'(got_dat.size()), 32'(exp_nw));
    check({nm, "_word_cnt"}, 32'(word_cnt), 32'(exp_nw));
    check({nm, "_stable"}, 32'(stab_err), 32'd0);
    if (exp_nw == 0) begin
      check({nm, "_rdreq_cycles"}, 32'(rdreq_cyc), 32'd0);
      check({nm, "_valid_cycles"}, 32'(valid_cyc), 32'd0);
    end
    for (int i = 0; i < exp_nw && i < got_dat.size(); i++) begin
      check($sformatf("%s_dat%0d", nm, i), got_dat[i], mem(b + 32'(4 * i)));
      check($sformatf("%s_last%0d", nm, i), 32'(got_last[i]), 32'(i == exp_nw - 1));
    end
  endtask

  task automatic run_dump(input string nm, input logic [31:0] b, input logic [31:0] e,
                          input bit wb, input bit we, input int rm, input int lat, input int gm,
                          input bit junk, input int noise, input bit extra,
                          input bit exp_err, input int exp_nw);
    rmode = rm; lat_cfg = lat; gnt_mod = gm;
    arm();
    repeat (noise) wr(32'h4000_1000 + 32'(4 * $urandom_range(0, 255)), $urandom);
    if (extra && wb) wr(BEGIN_A, $urandom);
    if (wb) wr(BEGIN_A, b);
    if (we) wr(END_A, e);
    wr(HALT_A, 32'h1);
    wait_end(nm, junk);
    verify(nm, b, exp_err, exp_nw);
  endtask

  // Reference: what a correct dump of [b, e) looks like, in plain integer arithmetic.
  function automatic void model(input logic [31:0] b, input logic [31:0] e, input bit bv,
                                input bit ev, output bit er, output int nw);
    longint lb, le;
    lb = longint'({32'h0, b});
    le = longint'({32'h0, e});
    er = !bv || !ev || (le < lb) || (lb < 64'sh4000_0000) || (lb % 4 != 0) ||
         (le % 4 != 0) || ((le - lb) / 4 > 8);
    nw = er ? 0 : int'((le - lb) / 4);
  endfunction

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    bit          wb;
    bit          we;
    int          rm;
    int          lat;
    int          gm;
    bit          exp_err;
    int          exp_nw;
  } vec_t;

  vec_t tv[13];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    tv[0]  = '{32'h4000_0100, 32'h4000_0110, 1'b1, 1'b1, 0, 1, 1, 1'b0, 4};
    tv[1]  = '{32'h4000_0100, 32'h4000_0110, 1'b1, 1'b1, 1, 3, 1, 1'b0, 4};
    tv[2]  = '{32'h4000_0200, 32'h4000_0200, 1'b1, 1'b1, 0, 1, 1, 1'b0, 0};
    tv[3]  = '{32'h4000_0110, 32'h4000_0100, 1'b1, 1'b1, 0, 1, 1, 1'b1, 0};
    tv[4]  = '{32'h4000_0100, 32'h4000_0110, 1'b1, 1'b0, 0, 1, 1, 1'b1, 0};
    tv[5]  = '{32'h3FFF_FFF0, 32'h4000_0000, 1'b1, 1'b1, 0, 1, 1, 1'b1, 0};
    tv[6]  = '{32'h4000_0102, 32'h4000_0112, 1'b1, 1'b1, 0, 1, 1, 1'b1, 0};
    tv[7]  = '{32'h4000_0100, 32'h4000_0112, 1'b1, 1'b1, 0, 1, 1, 1'b1, 0};
    tv[8]  = '{32'h4000_0000, 32'h4000_0020, 1'b1, 1'b1, 2, 2, 2, 1'b0, 8};
    tv[9]  = '{32'h4000_0000, 32'h4000_0024, 1'b1, 1'b1, 0, 1, 1, 1'b1, 0};
    tv[10] = '{32'h4000_0100, 32'h4000_0110, 1'b0, 1'b1, 0, 1, 1, 1'b1, 0};
    tv[11] = '{32'h3FFF_FFFC, 32'h4000_0004, 1'b1, 1'b1, 0, 1, 1, 1'b1, 0};
    tv[12] = '{32'h4000_0000, 32'h4000_0004, 1'b1, 1'b1, 1, 5, 3, 1'b0, 1};

    rst_n = 1'b0; enable = 1'b0; mon_we = 1'b0; mon_addr = 32'h0; mon_wdat = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_range", 32'(err_range), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_sig_valid", 32'(sig_valid), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    check("rst_sig_data", sig_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      run_dump($sformatf("vec%0d", i), tv[i].b, tv[i].e, tv[i].wb, tv[i].we, tv[i].rm,
               tv[i].lat, tv[i].gm, 1'b0, 0, 1'b0, tv[i].exp_err, tv[i].exp_nw);

    // Halt at cycle N: CHECK at N+1, rd_req with the begin address at N+2.
    rmode = 0; lat_cfg = 1; gnt_mod = 1;
    arm();
    wr(BEGIN_A, 32'h4000_0300);
    wr(END_A, 32'h4000_0308);
    mon_we = 1'b1; mon_addr = HALT_A; mon_wdat = 32'h1;
    @(negedge clk);
    mon_we = 1'b0;
    check("lat_check_rd_req", 32'(rd_req), 32'd0);
    check("lat_check_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_rd_req", 32'(rd_req), 32'd1);
    check("lat_rd_addr", rd_addr, 32'h4000_0300);
    wait_end("lat", 1'b0);
    verify("lat", 32'h4000_0300, 1'b0, 2);

    // Empty signature: done two cycles after the halt write, no output words.
    arm();
    wr(BEGIN_A, 32'h4000_0400);
    wr(END_A, 32'h4000_0400);
    mon_we = 1'b1; mon_addr = HALT_A; mon_wdat = 32'h1;
    @(negedge clk);
    mon_we = 1'b0;
    check("empty_done_n1", 32'(done), 32'd0);
    @(negedge clk);
    check("empty_done_n2", 32'(done), 32'd1);
    check("empty_valid_cycles", 32'(valid_cyc), 32'd0);

    // Watchdog: 15 armed cycles with no halt.
    arm();
    repeat (14) @(negedge clk);
    check("tmo_before", 32'(err_timeout), 32'd0);
    check("tmo_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_after", 32'(err_timeout), 32'd1);
    check("tmo_busy_after", 32'(busy), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    check("tmo_idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("tmo_rearm_cleared", 32'(err_timeout), 32'd0);
    check("tmo_rearm_busy", 32'(busy), 32'd1);
    enable = 1'b0;

    // Abort while word 2 is presented, then a full clean dump.
    rmode = 3; manual_rdy = 1'b0; lat_cfg = 1; gnt_mod = 1;
    arm();
    wr(BEGIN_A, 32'h4000_0100);
    wr(END_A, 32'h4000_0110);
    wr(HALT_A, 32'h1);
    wait_valid("abort_word1_valid");
    manual_rdy = 1'b1;
    @(negedge clk);
    manual_rdy = 1'b0;
    wait_valid("abort_word2_valid");
    enable = 1'b0;
    @(negedge clk);
    check("abort_sig_valid", 32'(sig_valid), 32'd0);
    check("abort_rd_req", 32'(rd_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_nwords", 32'(got_dat.size()), 32'd1);
    run_dump("rearm", 32'h4000_0100, 32'h4000_0110, 1'b1, 1'b1, 0, 1, 1, 1'b0, 0, 1'b0, 1'b0, 4);

    // Reset in the middle of a dump.
    rmode = 2; lat_cfg = 3; gnt_mod = 1;
    arm();
    wr(BEGIN_A, 32'h4000_0100);
    wr(END_A, 32'h4000_0120);
    wr(HALT_A, 32'h1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_req", 32'(rd_req), 32'd0);
    check("midrst_sig_valid", 32'(sig_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_word_cnt", 32'(word_cnt), 32'd0);
    check("midrst_sig_data", sig_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] b, e;
      bit          bv, ev, er;
      int          nw, len;
      b = 32'h4000_0000 - 32'd8 + 32'(4 * $urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) b = b + 32'd2;
      len = int'($urandom_range(0, 10));
      e = b + 32'(4 * len);
      if ($urandom_range(0, 7) == 0) e = b - 32'd4;
      bv = ($urandom_range(0, 9) != 0);
      ev = ($urandom_range(0, 9) != 0);
      model(b, e, bv, ev, er, nw);
      run_dump($sformatf("rnd%0d", i), b, e, bv, ev, int'($urandom_range(0, 2)),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1'b1,
               int'($urandom_range(0, 3)), 1'b1, er, nw);
    end

    enable = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
